// File: rtl/ddr3_cmd_sequencer.sv
// DDR3 x8 single-rank command sequencer: power-up/MRS/ZQ init, closed-page
// ACT + RD/WR auto-precharge accesses, and periodic all-bank refresh.
module ddr3_cmd_sequencer #(
  parameter int          ADDR_BITS = 14,
  parameter int          BA_BITS   = 3,
  parameter int          COL_BITS  = 10,
  parameter int          T_RSTL    = 16,
  parameter int          T_CKE     = 32,
  parameter int          T_XPR     = 20,
  parameter int          T_MRD     = 4,
  parameter int          T_MOD     = 12,
  parameter int          T_ZQINIT  = 64,
  parameter int          T_RCD     = 6,
  parameter int          T_RD_AP   = 10,
  parameter int          T_WR_AP   = 16,
  parameter int          T_RP      = 6,
  parameter int          T_RFC     = 44,
  parameter int          T_REFI    = 780,
  parameter logic [15:0] MR0       = 16'h0000,
  parameter logic [15:0] MR1       = 16'h0000,
  parameter logic [15:0] MR2       = 16'h0000,
  parameter logic [15:0] MR3       = 16'h0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [BA_BITS-1:0]   req_bank,
  input  logic [ADDR_BITS-1:0] req_row,
  input  logic [COL_BITS-1:0]  req_col,
  output logic                 rd_start,
  output logic                 wr_start,
  output logic                 init_done,
  output logic                 ddr_rst_n,
  output logic                 ddr_cke,
  output logic                 ddr_cs_n,
  output logic                 ddr_ras_n,
  output logic                 ddr_cas_n,
  output logic                 ddr_we_n,
  output logic [BA_BITS-1:0]   ddr_ba,
  output logic [ADDR_BITS-1:0] ddr_addr,
  output logic                 ddr_odt
);

  typedef enum logic [3:0] {
    S_RST_HOLD,
    S_CKE_WAIT,
    S_W_MRS2,
    S_W_MRS3,
    S_W_MRS1,
    S_W_MRS0,
    S_W_ZQCL,
    S_W_INIT,
    S_IDLE,
    S_ACT,
    S_W_COL,
    S_W_REF,
    S_W_IDLE
  } state_t;

  localparam logic [3:0] C_DES = 4'b1111;
  localparam logic [3:0] C_NOP = 4'b0111;
  localparam logic [3:0] C_MRS = 4'b0000;
  localparam logic [3:0] C_REF = 4'b0001;
  localparam logic [3:0] C_PRE = 4'b0010;
  localparam logic [3:0] C_ACT = 4'b0011;
  localparam logic [3:0] C_WR  = 4'b0100;
  localparam logic [3:0] C_RD  = 4'b0101;
  localparam logic [3:0] C_ZQ  = 4'b0110;

  localparam logic [ADDR_BITS-1:0] L_A10 = ADDR_BITS'(32'd1 << 10);

  state_t                 r_state;
  logic [15:0]            r_cnt;
  logic [15:0]            r_refi;
  logic                   r_ref_pend;
  logic                   r_init_done;
  logic                   r_rst_n;
  logic                   r_cke;
  logic [3:0]             r_cmd;
  logic [BA_BITS-1:0]     r_ba;
  logic [ADDR_BITS-1:0]   r_addr;
  logic                   r_odt;
  logic                   r_rd_start;
  logic                   r_wr_start;
  logic                   r_we;
  logic [BA_BITS-1:0]     r_bank;
  logic [ADDR_BITS-1:0]   r_row;
  logic [COL_BITS-1:0]    r_col;

  logic                   w_go;
  logic [ADDR_BITS-1:0]   w_col_addr;

  assign w_go = (r_cnt == '0);

  always_comb begin
    w_col_addr = L_A10;
    w_col_addr[COL_BITS-1:0] = r_col;
  end

  assign req_ready = (r_state == S_IDLE) && r_init_done && !r_ref_pend;

  assign rd_start  = r_rd_start;
  assign wr_start  = r_wr_start;
  assign init_done = r_init_done;
  assign ddr_rst_n = r_rst_n;
  assign ddr_cke   = r_cke;
  assign ddr_cs_n  = r_cmd[3];
  assign ddr_ras_n = r_cmd[2];
  assign ddr_cas_n = r_cmd[1];
  assign ddr_we_n  = r_cmd[0];
  assign ddr_ba    = r_ba;
  assign ddr_addr  = r_addr;
  assign ddr_odt   = r_odt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_RST_HOLD;
      r_cnt       <= 16'(T_RSTL - 1);
      r_refi      <= '0;
      r_ref_pend  <= 1'b0;
      r_init_done <= 1'b0;
      r_rst_n     <= 1'b0;
      r_cke       <= 1'b0;
      r_cmd       <= C_DES;
      r_ba        <= '0;
      r_addr      <= '0;
      r_odt       <= 1'b0;
      r_rd_start  <= 1'b0;
      r_wr_start  <= 1'b0;
      r_we        <= 1'b0;
      r_bank      <= '0;
      r_row       <= '0;
      r_col       <= '0;
    end else begin
      r_cmd      <= r_cke ? C_NOP : C_DES;
      r_odt      <= 1'b0;
      r_rd_start <= 1'b0;
      r_wr_start <= 1'b0;
      if (!w_go) r_cnt <= r_cnt - 16'd1;

      unique case (r_state)
        S_RST_HOLD: if (w_go) begin
          r_rst_n <= 1'b1;
          r_cnt   <= 16'(T_CKE - 1);
          r_state <= S_CKE_WAIT;
        end
        S_CKE_WAIT: if (w_go) begin
          r_cke   <= 1'b1;
          r_cmd   <= C_NOP;
          r_cnt   <= 16'(T_XPR - 1);
          r_state <= S_W_MRS2;
        end
        S_W_MRS2: if (w_go) begin
          r_cmd   <= C_MRS;
          r_ba    <= BA_BITS'(2);
          r_addr  <= MR2[ADDR_BITS-1:0];
          r_cnt   <= 16'(T_MRD - 1);
          r_state <= S_W_MRS3;
        end
        S_W_MRS3: if (w_go) begin
          r_cmd   <= C_MRS;
          r_ba    <= BA_BITS'(3);
          r_addr  <= MR3[ADDR_BITS-1:0];
          r_cnt   <= 16'(T_MRD - 1);
          r_state <= S_W_MRS1;
        end
        S_W_MRS1: if (w_go) begin
          r_cmd   <= C_MRS;
          r_ba    <= BA_BITS'(1);
          r_addr  <= MR1[ADDR_BITS-1:0];
          r_cnt   <= 16'(T_MRD - 1);
          r_state <= S_W_MRS0;
        end
        S_W_MRS0: if (w_go) begin
          r_cmd   <= C_MRS;
          r_ba    <= '0;
          r_addr  <= MR0[ADDR_BITS-1:0];
          r_cnt   <= 16'(T_MOD - 1);
          r_state <= S_W_ZQCL;
        end
        S_W_ZQCL: if (w_go) begin
          r_cmd   <= C_ZQ;
          r_addr  <= L_A10;
          r_cnt   <= 16'(T_ZQINIT - 1);
          r_state <= S_W_INIT;
        end
        S_W_INIT: if (w_go) begin
          r_init_done <= 1'b1;
          r_refi      <= 16'(T_REFI - 1);
          r_state     <= S_IDLE;
        end
        S_IDLE: begin
          if (r_ref_pend) begin
            r_cmd   <= C_PRE;
            r_addr  <= L_A10;
            r_cnt   <= 16'(T_RP - 1);
            r_state <= S_W_REF;
          end else if (req_valid) begin
            r_we    <= req_we;
            r_bank  <= req_bank;
            r_row   <= req_row;
            r_col   <= req_col;
            r_state <= S_ACT;
          end
        end
        S_ACT: begin
          r_cmd   <= C_ACT;
          r_ba    <= r_bank;
          r_addr  <= r_row;
          r_cnt   <= 16'(T_RCD - 1);
          r_state <= S_W_COL;
        end
        S_W_COL: if (w_go) begin
          r_cmd      <= r_we ? C_WR : C_RD;
          r_ba       <= r_bank;
          r_addr     <= w_col_addr;
          r_rd_start <= !r_we;
          r_wr_start <= r_we;
          r_cnt      <= r_we ? 16'(T_WR_AP - 1) : 16'(T_RD_AP - 1);
          r_state    <= S_W_IDLE;
        end
        S_W_REF: if (w_go) begin
          r_cmd      <= C_REF;
          r_ref_pend <= 1'b0;
          r_cnt      <= 16'(T_RFC - 1);
          r_state    <= S_W_IDLE;
        end
        S_W_IDLE: if (w_go) begin
          r_state <= S_IDLE;
        end
        default: r_state <= S_RST_HOLD;
      endcase

      // placed after the FSM so an expiry on the REF edge keeps ref_pend set
      if (r_init_done) begin
        if (r_refi == '0) begin
          r_refi     <= 16'(T_REFI - 1);
          r_ref_pend <= 1'b1;
        end else begin
          r_refi <= r_refi - 16'd1;
        end
      end
    end
  end

endmodule
